mario_sprite_fetch: RTL and testbench

//  Upstream address stage for the 21x21 Mario sprite ROMs. Compares the VGA pixel (DrawX, DrawY)
//  to Mario's position and issues read_address plus a sprite/ROM select (pose x facing).

---
 rtl/mario_sprite_pkg.sv | 17 +
 rtl/mario_pose_fsm.sv | 75 +++++++
 rtl/mario_sprite_fetch.sv | 89 ++++++++
 tb/tb_mario_sprite_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_sprite_pkg.sv
// Shared types and constants for the Mario sprite fetch path.
// Pose encoding doubles as the low two bits of the sprite ROM select.
package mario_sprite_pkg;

    typedef enum logic [1:0] {
        STAND  = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2,
        JUMP   = 2'd3
    } pose_t;

    localparam int          SPR_W        = 21;
    localparam int          SPR_H        = 21;
    localparam logic [23:0] KEY_COLOR    = 24'h800080;
    localparam int          SPRITE_SEL_W = 3;

endpackage

// File: rtl/mario_pose_fsm.sv
// Frame-rate pose FSM: syncs frame_clk, picks stand/walk/jump art and latches facing.
// sprite_sel changes 3 clk after a frame_clk rising edge; never stalls, no backpressure.
module mario_pose_fsm
    import mario_sprite_pkg::*;
#(
    parameter int WALK_PERIOD = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic                    moving,
    input  logic                    airborne,
    input  logic                    facing_left,
    output logic [SPRITE_SEL_W-1:0] sprite_sel
);

    localparam int               CNT_W    = $clog2(WALK_PERIOD) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WALK_PERIOD - 1);

    logic             fsync1;
    logic             fsync2;
    logic             fprev;
    logic             frame_tick;
    pose_t            pose;
    logic [CNT_W-1:0] walk_cnt;
    logic             facing;

    assign frame_tick = fsync2 & ~fprev;
    assign sprite_sel = {facing, pose};

    // Pose, counter and facing only move on frame_tick so art is stable for a whole frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync1   <= 1'b0;
            fsync2   <= 1'b0;
            fprev    <= 1'b0;
            pose     <= STAND;
            walk_cnt <= '0;
            facing   <= 1'b0;
        end else begin
            fsync1 <= frame_clk;
            fsync2 <= fsync1;
            fprev  <= fsync2;
            if (frame_tick) begin
                if (pose != JUMP)
                    facing <= facing_left;
                walk_cnt <= '0;
                case (pose)
                    STAND: begin
                        if (airborne)
                            pose <= JUMP;
                        else if (moving)
                            pose <= WALK_A;
                    end
                    WALK_A, WALK_B: begin
                        if (airborne)
                            pose <= JUMP;
                        else if (!moving)
                            pose <= STAND;
                        else if (walk_cnt == CNT_LAST)
                            pose <= (pose == WALK_A) ? WALK_B : WALK_A;
                        else
                            walk_cnt <= walk_cnt + CNT_W'(1);
                    end
                    JUMP: begin
                        if (!airborne)
                            pose <= moving ? WALK_A : STAND;
                    end
                    default: pose <= STAND;
                endcase
            end
        end
    end

endmodule

// File: rtl/mario_sprite_fetch.sv
// Sprite address stage: hit-tests the VGA pixel against Mario's box, addresses the ROM, flags key colour.
// Latency 1 clk to read_address, 2 clk to pixel_*; 1 pixel/clk, no backpressure (always advances).
module mario_sprite_fetch
    import mario_sprite_pkg::*;
#(
    parameter int                 SPR_W       = mario_sprite_pkg::SPR_W,
    parameter int                 SPR_H       = mario_sprite_pkg::SPR_H,
    parameter int                 ADDR_W      = 9,
    parameter int                 COLOR_W     = 24,
    parameter logic [COLOR_W-1:0] KEY_COLOR   = mario_sprite_pkg::KEY_COLOR,
    parameter int                 WALK_PERIOD = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic                    pix_valid,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [9:0]              MarioX,
    input  logic [9:0]              MarioY,
    input  logic                    moving,
    input  logic                    airborne,
    input  logic                    facing_left,
    output logic [ADDR_W-1:0]       read_address,
    output logic [SPRITE_SEL_W-1:0] sprite_sel,
    input  logic [COLOR_W-1:0]      rom_color,
    output logic [COLOR_W-1:0]      pixel_color,
    output logic                    pixel_opaque,
    output logic                    pixel_valid_o
);

    logic [10:0]       px;
    logic [10:0]       py;
    logic [10:0]       x_lo;
    logic [10:0]       x_hi;
    logic [10:0]       y_lo;
    logic [10:0]       y_hi;
    logic              in_box;
    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [ADDR_W-1:0] addr_nxt;
    logic              s1_inbox;
    logic              s1_valid;

    // 11-bit compare so a sprite hanging off the right/bottom edge never wraps to column 0.
    assign px   = {1'b0, DrawX};
    assign py   = {1'b0, DrawY};
    assign x_lo = {1'b0, MarioX};
    assign y_lo = {1'b0, MarioY};
    assign x_hi = x_lo + 11'(SPR_W);
    assign y_hi = y_lo + 11'(SPR_H);

    assign in_box = pix_valid && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

    assign dx       = DrawX - MarioX;
    assign dy       = DrawY - MarioY;
    assign addr_nxt = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address  <= '0;
            s1_inbox      <= 1'b0;
            s1_valid      <= 1'b0;
            pixel_color   <= '0;
            pixel_opaque  <= 1'b0;
            pixel_valid_o <= 1'b0;
        end else begin
            read_address  <= in_box ? addr_nxt : '0;
            s1_inbox      <= in_box;
            s1_valid      <= pix_valid;
            pixel_color   <= s1_inbox ? rom_color : '0;
            pixel_opaque  <= s1_valid & s1_inbox & (rom_color != KEY_COLOR);
            pixel_valid_o <= s1_valid;
        end
    end

    mario_pose_fsm #(
        .WALK_PERIOD (WALK_PERIOD)
    ) u_pose_fsm (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .moving      (moving),
        .airborne    (airborne),
        .facing_left (facing_left),
        .sprite_sel  (sprite_sel)
    );

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Randomized bench for mario_sprite_fetch against a cycle-level behavioural model.
module tb_mario_sprite_fetch;
    import mario_sprite_pkg::*;

    localparam int          WP   = 6;
    localparam int          FPER = 6;
    localparam logic [23:0] KEY  = 24'h800080;
    localparam logic [23:0] RED  = 24'hF83800;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
    logic        moving = 1'b0, airborne = 1'b0, facing_left = 1'b0;
    logic [8:0]  read_address;
    logic [2:0]  sprite_sel;
    logic [23:0] rom_color;
    logic [23:0] pixel_color;
    logic        pixel_opaque;
    logic        pixel_valid_o;
    int          rom_mode = 0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state: what the DUT outputs should hold after the most recent edge
    int          m_addr, m_sel, m_pose, m_cnt, m_face;
    bit          m_inbox, m_valid, m_opaque, m_pvo;
    logic [23:0] m_color;
    bit          fq[$];

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_fn(input logic [2:0] s, input logic [8:0] a);
        return {5'b00010, s, 7'b0, a};
    endfunction

    assign rom_color = (rom_mode == 1) ? KEY : (rom_mode == 2) ? RED : rom_fn(sprite_sel, read_address);

    mario_sprite_fetch dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .pix_valid     (pix_valid),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .MarioX        (MarioX),
        .MarioY        (MarioY),
        .moving        (moving),
        .airborne      (airborne),
        .facing_left   (facing_left),
        .read_address  (read_address),
        .sprite_sel    (sprite_sel),
        .rom_color     (rom_color),
        .pixel_color   (pixel_color),
        .pixel_opaque  (pixel_opaque),
        .pixel_valid_o (pixel_valid_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_sel = 0; m_pose = 0; m_cnt = 0; m_face = 0;
        m_inbox = 0; m_valid = 0; m_opaque = 0; m_pvo = 0; m_color = '0;
        fq = '{0, 0, 0, 0};
    endtask

    // Advance the model across one clock edge using the inputs that were stable before it.
    task automatic model_edge();
        logic [23:0] rc;
        bit          tick;
        bit          in;
        int          nx;
        int          x, y, mx, my;
        rc = (rom_mode == 1) ? KEY : (rom_mode == 2) ? RED : rom_fn(3'(m_sel), 9'(m_addr));
        m_color  = m_inbox ? rc : 24'h0;
        m_opaque = m_valid && m_inbox && (rc != KEY);
        m_pvo    = m_valid;

        // a frame_clk rise becomes visible to the pose logic three edges after it is driven
        fq.push_back(frame_clk);
        tick = fq[$-2] && !fq[$-3];
        void'(fq.pop_front());
        if (tick) begin
            if (m_pose != 3) m_face = facing_left;
            if (m_pose == 3)    nx = airborne ? 3 : (moving ? 1 : 0);
            else if (airborne)  nx = 3;
            else if (!moving)   nx = 0;
            else if (m_pose == 0) nx = 1;
            else begin
                m_cnt++;
                nx = (m_cnt == WP) ? 3 - m_pose : m_pose;
            end
            if (nx != m_pose) m_cnt = 0;
            m_pose = nx;
        end
        m_sel = m_face * 4 + m_pose;

        x = DrawX; y = DrawY; mx = MarioX; my = MarioY;
        in = pix_valid && x >= mx && x < mx + 21 && y >= my && y < my + 21;
        m_addr  = in ? (y - my) * 21 + (x - mx) : 0;
        m_inbox = in;
        m_valid = pix_valid;
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (Reset_n) model_edge();
        #1;
        cyc++;
        check_val("read_address", read_address, m_addr);
        check_val("sprite_sel", sprite_sel, m_sel);
        check_val("pixel_color", pixel_color, m_color);
        check_val("pixel_opaque", pixel_opaque, m_opaque);
        check_val("pixel_valid_o", pixel_valid_o, m_pvo);
        frame_clk = (cyc % FPER) < (FPER / 2);
    endtask

    task automatic set_px(input bit v, input int x, input int y, input int mx, input int my);
        pix_valid = v;
        DrawX = 10'(x); DrawY = 10'(y); MarioX = 10'(mx); MarioY = 10'(my);
    endtask

    task automatic rand_px();
        int r;
        pix_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
            DrawX = 10'($urandom); DrawY = 10'($urandom);
        end else begin
            DrawX = 10'(int'(MarioX) + int'($urandom_range(0, 24)) - 2);
            DrawY = 10'(int'(MarioY) + int'($urandom_range(0, 24)) - 2);
        end
        r = int'($urandom_range(0, 3));
        rom_mode = (r == 2) ? 1 : (r == 3) ? 2 : 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_addr"}, read_address, 0);
        check_val({tag, "_sel"}, sprite_sel, 0);
        check_val({tag, "_color"}, pixel_color, 0);
        check_val({tag, "_opaque"}, pixel_opaque, 0);
        check_val({tag, "_valid"}, pixel_valid_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_zero_outputs("reset");
        Reset_n = 1'b1;

        // worked address example and colour keying
        rom_mode = 2;
        set_px(1, 105, 203, 100, 200);
        cycle();
        check_val("addr_68", read_address, 68);
        cycle();
        check_val("valid_2clk", pixel_valid_o, 1);
        check_val("red_opaque", pixel_opaque, 1);
        check_val("red_color", pixel_color, RED);
        rom_mode = 1;
        cycle();
        check_val("key_transparent", pixel_opaque, 0);
        check_val("key_color", pixel_color, KEY);
        rom_mode = 0;

        // box edges
        set_px(1, 120, 203, 100, 200); cycle();
        check_val("edge_x120", read_address, 83);
        set_px(1, 121, 203, 100, 200); cycle();
        check_val("edge_x121", read_address, 0);
        set_px(1, 120, 220, 100, 200); cycle();
        check_val("edge_max440", read_address, 440);
        set_px(1, 105, 221, 100, 200); cycle();
        check_val("edge_y221", read_address, 0);
        set_px(1, 2, 203, 1015, 200); cycle();
        check_val("nowrap_addr", read_address, 0);
        set_px(0, 105, 203, 100, 200); cycle();
        check_val("nowrap_opaque", pixel_opaque, 0);
        cycle();
        check_val("novalid_opaque", pixel_opaque, 0);
        check_val("novalid_valid", pixel_valid_o, 0);

        // walking: enough ticks to toggle WALK_A/WALK_B twice
        MarioX = 10'd300; MarioY = 10'd100;
        moving = 1; airborne = 0; facing_left = 0;
        for (int i = 0; i < 14 * FPER; i++) begin
            rand_px();
            if (i % 5 == 4) facing_left = ~facing_left;
            cycle();
        end
        // jump with facing toggling, then land standing
        airborne = 1;
        for (int i = 0; i < 6 * FPER; i++) begin
            rand_px();
            if (i % 4 == 3) facing_left = ~facing_left;
            cycle();
        end
        airborne = 0; moving = 0;
        for (int i = 0; i < 4 * FPER; i++) begin
            rand_px();
            cycle();
        end

        // free-running random traffic with a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            rand_px();
            if ($urandom_range(0, 15) == 0) moving = ~moving;
            if ($urandom_range(0, 23) == 0) airborne = ~airborne;
            if ($urandom_range(0, 7) == 0) facing_left = ~facing_left;
            if ($urandom_range(0, 49) == 0) begin
                MarioX = 10'($urandom_range(990, 1023));
                MarioY = 10'($urandom);
            end else if ($urandom_range(0, 49) == 0) begin
                MarioX = 10'($urandom); MarioY = 10'($urandom_range(0, 600));
            end
            if (i == 200) begin
                Reset_n = 1'b0;
                model_reset();
                #1;
                check_zero_outputs("midreset");
                repeat (3) cycle();
                Reset_n = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
